// File: rtl/mux_gate_arbiter_if.sv
// Requester-side bus of mux_gate_arbiter: per-requester request/operands/function
// in, grant pulse and tagged result out.
interface mux_gate_arbiter_if #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
);
  logic [N-1:0]   req;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [2*N-1:0] op;
  logic [N-1:0]   gnt;
  logic           done;
  logic           result;
  logic [IDW-1:0] done_id;
  logic           busy;

  // Requesters drive requests and operands
  modport master (
    output req, a, b, op,
    input  gnt, done, result, done_id, busy
  );

  // Arbiter consumes requests and returns grant/result
  modport slave (
    input  req, a, b, op,
    output gnt, done, result, done_id, busy
  );
endinterface

// File: rtl/mux_gate_arbiter.sv
// Round-robin arbiter that time-shares one 2:1 mux between N requesters, each
// asking for AND/OR/XOR/NAND of its own operands. IDLE -> EVAL -> RESP sequence,
// all outputs registered.
// Optional macro MUX_GATE_ARB_STATS_EN adds a served-operation counter
// (served_cnt) with synchronous clear (stats_clr).
module mux_gate_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef MUX_GATE_ARB_STATS_EN
  input  logic                 stats_clr,
  output logic [15:0]          served_cnt,
`endif
  mux_gate_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StEval, StResp} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] id_q, id_d;
  logic           a_q, a_d;
  logic           b_q, b_d;
  logic [1:0]     op_q, op_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           done_q, done_d;
  logic           result_q, result_d;
  logic [IDW-1:0] done_id_q, done_id_d;
  logic           busy_q, busy_d;

  logic           win_vld;
  logic [IDW-1:0] win_id;
  logic           mux_i0, mux_i1, mux_out;

  // Round-robin search starting one past the last winner
  always_comb begin
    int unsigned idx;
    idx     = 0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last_q) + k) % N;
      if (!win_vld && bus.req[idx]) begin
        win_vld = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  // Map the latched function onto the shared mux: out = a ? i1 : i0
  always_comb begin
    mux_i0 = 1'b1;
    mux_i1 = ~b_q;
    case (op_q)
      2'b00: begin mux_i0 = 1'b0; mux_i1 = b_q;  end // AND
      2'b01: begin mux_i0 = b_q;  mux_i1 = 1'b1; end // OR
      2'b10: begin mux_i0 = b_q;  mux_i1 = ~b_q; end // XOR
      default: begin mux_i0 = 1'b1; mux_i1 = ~b_q; end // NAND
    endcase
    mux_out = a_q ? mux_i1 : mux_i0;
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    gnt_d     = '0;
    done_d    = 1'b0;
    result_d  = result_q;
    done_id_d = done_id_q;
    busy_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (win_vld) begin
          state_d       = StEval;
          last_d        = win_id;
          id_d          = win_id;
          a_d           = bus.a[win_id];
          b_d           = bus.b[win_id];
          op_d          = bus.op[{win_id, 1'b0} +: 2];
          gnt_d[win_id] = 1'b1;
        end
      end
      StEval: begin
        state_d   = StResp;
        result_d  = mux_out;
        done_d    = 1'b1;
        done_id_d = id_q;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and registered outputs; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      last_q    <= IDW'(N - 1);
      id_q      <= '0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      op_q      <= 2'b00;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      result_q  <= 1'b0;
      done_id_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      id_q      <= id_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      result_q  <= result_d;
      done_id_q <= done_id_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.done_id = done_id_q;
  assign bus.busy    = busy_q;

`ifdef MUX_GATE_ARB_STATS_EN
  logic [15:0] served_q;

  // Count completed operations; clear has priority, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      served_q <= '0;
    end else if (stats_clr) begin
      served_q <= '0;
    end else if (state_q == StResp) begin
      served_q <= served_q + 16'd1;
    end
  end

  assign served_cnt = served_q;
`endif

endmodule

// File: tb/tb_mux_gate_arbiter.sv
// Self-checking bench for mux_gate_arbiter: transaction-level model predicts
// grants, pushes expected results to a scoreboard, pops them on done.
module tb_mux_gate_arbiter;
  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           res;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_gate_arbiter_if #(.N(N), .IDW(IDW)) bus ();

  mux_gate_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [N-1:0]   req_smp, a_smp, b_smp;
  logic [2*N-1:0] op_smp;
  logic           rst_smp = 1'b0;
  logic           hold    = 1'b0;
  logic [N-1:0]   gl      = '0;

  int   m_st   = 0;  // 0 idle, 1 eval, 2 resp
  int   m_last = N - 1;
  int   m_win  = 0;
  logic m_res  = 1'b0;
  int   waitc[N];
  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic fref(input logic a, input logic b, input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic int rr(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Advance the reference model by one cycle and compare DUT outputs
  task automatic model_check();
    logic [N-1:0] exp_gnt;
    exp_t e;
    int w;
    if (!rst_n) begin
      m_st = 0; m_last = N - 1; m_res = 1'b0;
      q.delete();
      for (int i = 0; i < N; i++) waitc[i] = 0;
      chk("reset_outs", 32'({bus.gnt, bus.done, bus.result, bus.done_id, bus.busy}), 32'd0);
      return;
    end
    if (rst_smp) begin
      case (m_st)
        0: if (req_smp != '0) begin
          w = rr(req_smp, m_last);
          chk("starve", 32'(waitc[w] <= N - 1), 32'd1);
          for (int i = 0; i < N; i++) begin
            if (i == w) waitc[i] = 0;
            else if (req_smp[i]) waitc[i]++;
          end
          e.id  = IDW'(w);
          e.res = fref(a_smp[w], b_smp[w], op_smp[2*w +: 2]);
          q.push_back(e);
          m_last = w; m_win = w; m_st = 1;
        end
        1: m_st = 2;
        default: m_st = 0;
      endcase
    end
    exp_gnt = '0;
    if (m_st == 1) exp_gnt[m_win] = 1'b1;
    chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
    chk("done", 32'(bus.done), 32'(m_st == 2));
    chk("busy", 32'(bus.busy), 32'(m_st != 0));
    if (m_st == 2) begin
      chk("sb_size", q.size(), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("done_id", 32'(bus.done_id), 32'(e.id));
        chk("result", 32'(bus.result), 32'(e.res));
        m_res = e.res;
      end
    end else begin
      chk("result_hold", 32'(bus.result), 32'(m_res));
    end
  endtask

  // One clock: sample inputs at the edge, apply requester drop, check at negedge
  task automatic cycle();
    @(posedge clk);
    req_smp = bus.req; a_smp = bus.a; b_smp = bus.b; op_smp = bus.op; rst_smp = rst_n;
    #1;
    if (!hold) bus.req = bus.req & ~gl;
    @(negedge clk);
    model_check();
    gl = bus.gnt;
  endtask

  task automatic wait_grant(input string tag);
    for (int n = 0; n < 12; n++) begin
      cycle();
      if (gl != '0) break;
    end
    chk(tag, 32'(gl != '0), 32'd1);
  endtask

  task automatic single(input int id, input logic a, input logic b, input logic [1:0] op);
    bus.req[id] = 1'b1;
    bus.a[id]   = a;
    bus.b[id]   = b;
    bus.op[2*id +: 2] = op;
    wait_grant("single_grant");
    chk("single_gnt", 32'(gl), 32'(1) << id);
    cycle();
    cycle();
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    bus.req = '0; bus.a = '0; bus.b = '0; bus.op = '0;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    repeat (3) cycle();
    #2 rst_n = 1'b1;
    repeat (4) cycle();  // idle, no requests

    // Contention from reset: expect 0,1,2,3,0
    hold = 1'b1;
    bus.req = '1;
    bus.a = 4'b1010; bus.b = 4'b0110; bus.op = 8'b11_10_01_00;
    k = 0;
    for (int n = 0; n < 40 && k < 5; n++) begin
      cycle();
      if (gl != '0) begin
        chk("cont_order", 32'(gl), 32'(1) << (k % N));
        k++;
      end
    end
    chk("cont_grants", k, 32'd5);
    cycle();
    bus.req = '0;
    hold = 1'b0;
    repeat (2) cycle();

    // Single requester, each function
    single(1, 1'b1, 1'b1, 2'b00);
    single(1, 1'b1, 1'b0, 2'b00);
    single(1, 1'b1, 1'b0, 2'b01);
    single(1, 1'b1, 1'b0, 2'b10);
    single(1, 1'b1, 1'b0, 2'b11);
    single(1, 1'b0, 1'b0, 2'b01);
    single(1, 1'b0, 1'b0, 2'b10);
    single(1, 1'b0, 1'b0, 2'b11);

    // Wrap: last grant 3, then 1001 -> 0 then 3
    single(3, 1'b0, 1'b1, 2'b01);
    hold = 1'b1;
    bus.req = 4'b1001; bus.a = 4'b1001; bus.b = 4'b0001; bus.op = 8'b10_00_00_00;
    wait_grant("wrap_first_seen");
    chk("wrap_first", 32'(gl), 32'd1);
    wait_grant("wrap_second_seen");
    chk("wrap_second", 32'(gl), 32'd8);
    bus.req = '0;
    hold = 1'b0;
    repeat (3) cycle();

    // Reset during EVAL: no done, outputs cleared, then normal operation
    bus.req = 4'b0100; bus.a = 4'b0100; bus.b = 4'b0100; bus.op = 8'b00_11_00_00;
    wait_grant("midrst_grant");
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 32'({bus.gnt, bus.done, bus.result, bus.done_id, bus.busy}), 32'd0);
    repeat (2) cycle();
    bus.req = '0;
    #2 rst_n = 1'b1;
    single(0, 1'b1, 1'b0, 2'b10);
    repeat (2) cycle();

    // Random traffic obeying the requester contract
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
          bus.req[i] = 1'b1;
          bus.a[i] = 1'($urandom_range(0, 1));
          bus.b[i] = 1'($urandom_range(0, 1));
          bus.op[2*i +: 2] = 2'($urandom_range(0, 3));
        end
      end
      cycle();
    end
    bus.req = '0;
    repeat (4) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
